// File: rtl/rtr_commit.sv
// rtr_commit: retire-commit stage; commits the ROB head's destination write, counts
// retired instructions, and runs the mispredict flush/redirect sequence.
module rtr_commit #(
  parameter int XLEN         = 32,
  parameter int PADDR_W      = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rtr_valid_rb1,
  input  logic               rtr_dst_valid_rb1,
  input  logic [4:0]         rtr_dst_addr_rb1,
  input  logic [XLEN-1:0]    rtr_result_rb1,
  input  logic               br_mispred_rb1,
  input  logic [PADDR_W-1:0] br_tgt_rb1,
  output logic               iwb_valid_rb2,
  output logic [4:0]         iwb_addr_rb2,
  output logic [XLEN-1:0]    iwb_data_rb2,
  output logic               flush_rb2,
  output logic               retire_stall,
  output logic               fe_redirect_valid,
  output logic [PADDR_W-1:0] fe_redirect_tgt,
  input  logic               fe_redirect_ack,
  output logic [63:0]        instret
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [PADDR_W-1:0] tgt;
  logic accept, wr, mispred;
  assign accept  = rtr_valid_rb1 && state == IDLE;
  assign mispred = accept && br_mispred_rb1;
  assign wr      = accept && rtr_dst_valid_rb1 && rtr_dst_addr_rb1 != 5'd0;
  // the counter idles at its load value, so entering FLUSH always starts from FLUSH_CYCLES-1
  always_comb begin
    state_nxt = state == IDLE  ? (mispred ? FLUSH : IDLE) :
                state == FLUSH ? (cnt == 4'd0 ? REDIRECT : FLUSH) :
                                 (fe_redirect_ack ? IDLE : REDIRECT);
    cnt_nxt   = state == FLUSH ? cnt - 4'd1 : 4'(FLUSH_CYCLES - 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      tgt           <= '0;
      instret       <= '0;
      iwb_valid_rb2 <= 1'b0;
      iwb_addr_rb2  <= '0;
      iwb_data_rb2  <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      iwb_valid_rb2 <= wr;
      if (mispred) tgt <= br_tgt_rb1;
      if (accept) instret <= instret + 64'd1;
      if (wr) begin
        iwb_addr_rb2 <= rtr_dst_addr_rb1;
        iwb_data_rb2 <= rtr_result_rb1;
      end
    end
  end
  assign flush_rb2         = state == FLUSH;
  assign retire_stall      = state != IDLE;
  assign fe_redirect_valid = state == REDIRECT;
  assign fe_redirect_tgt   = state == REDIRECT ? tgt : '0;
  // a retire while stalled is dropped; flag it without stopping simulation
  always @(posedge clk)
    if (!reset)
      assert (!(rtr_valid_rb1 && state != IDLE))
        else $warning("rtr_commit: retire while retire_stall is high was dropped");
endmodule

// File: tb/tb_rtr_commit.sv
// tb_rtr_commit: directed self-checking bench for rtr_commit.
module tb_rtr_commit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rtr_valid_rb1 = 1'b0, rtr_dst_valid_rb1 = 1'b0, br_mispred_rb1 = 1'b0;
  logic [4:0]  rtr_dst_addr_rb1 = '0;
  logic [31:0] rtr_result_rb1 = '0, br_tgt_rb1 = '0;
  logic        fe_redirect_ack = 1'b0;
  logic        iwb_valid_rb2, flush_rb2, retire_stall, fe_redirect_valid;
  logic [4:0]  iwb_addr_rb2;
  logic [31:0] iwb_data_rb2, fe_redirect_tgt;
  logic [63:0] instret;
  int checks = 0, failures = 0;

  rtr_commit dut (
    .clk(clk), .reset(reset),
    .rtr_valid_rb1(rtr_valid_rb1), .rtr_dst_valid_rb1(rtr_dst_valid_rb1),
    .rtr_dst_addr_rb1(rtr_dst_addr_rb1), .rtr_result_rb1(rtr_result_rb1),
    .br_mispred_rb1(br_mispred_rb1), .br_tgt_rb1(br_tgt_rb1),
    .iwb_valid_rb2(iwb_valid_rb2), .iwb_addr_rb2(iwb_addr_rb2), .iwb_data_rb2(iwb_data_rb2),
    .flush_rb2(flush_rb2), .retire_stall(retire_stall),
    .fe_redirect_valid(fe_redirect_valid), .fe_redirect_tgt(fe_redirect_tgt),
    .fe_redirect_ack(fe_redirect_ack), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then land on the following negedge for sampling
  task automatic step(input logic v, input logic dv, input logic [4:0] a, input logic [31:0] d,
                      input logic m, input logic [31:0] t, input logic ack);
    rtr_valid_rb1 = v; rtr_dst_valid_rb1 = dv; rtr_dst_addr_rb1 = a; rtr_result_rb1 = d;
    br_mispred_rb1 = m; br_tgt_rb1 = t; fe_redirect_ack = ack;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_iwb_valid", iwb_valid_rb2, 0);
    chk("rst_flush", flush_rb2, 0);
    chk("rst_stall", retire_stall, 0);
    chk("rst_redir", fe_redirect_valid, 0);
    chk("rst_instret", instret, 0);
    reset = 1'b0;
    step(1, 1, 5, 32'h11, 0, 0, 0);
    chk("x5_valid", iwb_valid_rb2, 1);
    chk("x5_addr", iwb_addr_rb2, 5);
    chk("x5_data", iwb_data_rb2, 32'h11);
    step(1, 1, 0, 32'h22, 0, 0, 0);
    chk("x0_valid", iwb_valid_rb2, 0);
    chk("x0_hold_addr", iwb_addr_rb2, 5);
    chk("x0_hold_data", iwb_data_rb2, 32'h11);
    step(1, 1, 7, 32'h33, 0, 0, 0);
    chk("x7_valid", iwb_valid_rb2, 1);
    chk("x7_addr", iwb_addr_rb2, 7);
    chk("x7_data", iwb_data_rb2, 32'h33);
    chk("instret3", instret, 3);
    step(0, 1, 9, 32'h44, 1, 32'h4000, 0);
    chk("unq_mis_flush", flush_rb2, 0);
    chk("unq_mis_stall", retire_stall, 0);
    chk("unq_iwb", iwb_valid_rb2, 0);
    chk("unq_instret", instret, 3);
    step(1, 1, 1, 32'h104, 1, 32'h2000, 0);
    chk("mis_iwb_valid", iwb_valid_rb2, 1);
    chk("mis_iwb_addr", iwb_addr_rb2, 1);
    chk("mis_iwb_data", iwb_data_rb2, 32'h104);
    chk("mis_instret", instret, 4);
    chk("flush1", flush_rb2, 1);
    chk("flush1_stall", retire_stall, 1);
    chk("flush1_redir", fe_redirect_valid, 0);
    chk("flush1_tgt", fe_redirect_tgt, 0);
    step(1, 1, 9, 32'h99, 0, 0, 0);
    chk("flush2", flush_rb2, 1);
    chk("viol_iwb", iwb_valid_rb2, 0);
    chk("viol_instret", instret, 4);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("redir1_flush", flush_rb2, 0);
    chk("redir1_valid", fe_redirect_valid, 1);
    chk("redir1_tgt", fe_redirect_tgt, 32'h2000);
    chk("redir1_stall", retire_stall, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("redir_hold_valid", fe_redirect_valid, 1);
      chk("redir_hold_tgt", fe_redirect_tgt, 32'h2000);
    end
    step(1, 1, 2, 32'h77, 1, 32'h5000, 1);
    chk("ack_stall", retire_stall, 0);
    chk("ack_redir", fe_redirect_valid, 0);
    chk("ack_tgt", fe_redirect_tgt, 0);
    chk("ack_flush", flush_rb2, 0);
    chk("ack_viol_iwb", iwb_valid_rb2, 0);
    chk("ack_viol_instret", instret, 4);
    step(1, 1, 0, 32'h88, 1, 32'h3000, 0);
    chk("b2b_flush", flush_rb2, 1);
    chk("b2b_x0_iwb", iwb_valid_rb2, 0);
    chk("b2b_instret", instret, 5);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("b2b_flush2", flush_rb2, 1);
    reset = 1'b1;
    #1;
    chk("arst_flush", flush_rb2, 0);
    chk("arst_stall", retire_stall, 0);
    chk("arst_redir", fe_redirect_valid, 0);
    chk("arst_instret", instret, 0);
    chk("arst_iwb_data", iwb_data_rb2, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("post_rst_redir", fe_redirect_valid, 0);
      chk("post_rst_stall", retire_stall, 0);
    end
    step(1, 1, 3, 32'h55, 0, 0, 0);
    chk("post_rst_valid", iwb_valid_rb2, 1);
    chk("post_rst_addr", iwb_addr_rb2, 3);
    chk("post_rst_data", iwb_data_rb2, 32'h55);
    chk("post_rst_instret", instret, 1);
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    chk("preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1, 0, 4, 32'h66, 0, 0, 0);
    chk("wrap_instret", instret, 0);
    chk("wrap_no_iwb", iwb_valid_rb2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
